// File: rtl/adder_ctrl_pkg.sv
// Shared state encoding, bsel codes and output decode for the adder control FSM.
package adder_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ADD_AB = 3'd2,
    ADD_C  = 3'd3,
    ADD_D  = 3'd4,
    OUT    = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [1:0] BSEL_AB  = 2'b00;
  localparam logic [1:0] BSEL_C   = 2'b01;
  localparam logic [1:0] BSEL_D   = 2'b10;
  localparam logic [1:0] BSEL_NOP = 2'b11;

  typedef struct packed {
    logic       load;
    logic       asel;
    logic [1:0] bsel;
    logic       output_enable;
    logic       busy;
    logic       done;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    load:          1'b0,
    asel:          1'b0,
    bsel:          BSEL_NOP,
    output_enable: 1'b0,
    busy:          1'b0,
    done:          1'b0
  };

  // Unsupported operand counts fall back to the full four-operand sum.
  function automatic int eff_num_ops(input int num_ops);
    return (num_ops == 2 || num_ops == 3) ? num_ops : 4;
  endfunction

  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c      = CTRL_IDLE;
    c.busy = (s != IDLE);
    case (s)
      LOAD:   c.load = 1'b1;
      ADD_AB: begin
        c.asel = 1'b1;
        c.bsel = BSEL_AB;
      end
      ADD_C:  c.bsel = BSEL_C;
      ADD_D:  c.bsel = BSEL_D;
      OUT:    c.output_enable = 1'b1;
      DONE:   c.done = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/adder_txn_counter.sv
// Wrapping count of completed adder transactions.
module adder_txn_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/adder_controller.sv
// Control FSM sequencing the four-operand adder datapath with a done/ack handshake.
// Optional transaction counter and txn_count port: define ADDER_CTRL_TXN_COUNT_EN.
module adder_controller
  import adder_ctrl_pkg::*;
#(
  parameter int NUM_OPS = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ack,
  output logic             aload,
  output logic             bload,
  output logic             cload,
  output logic             dload,
  output logic             asel,
  output logic [1:0]       bsel,
  output logic             output_enable,
  output logic             busy,
  output logic             done,
`ifdef ADDER_CTRL_TXN_COUNT_EN
  output logic [CNT_W-1:0] txn_count,
`endif
  output state_t           state_dbg
);

  localparam int OPS = eff_num_ops(NUM_OPS);

  // Handshake: start is honoured only in IDLE and ack only in DONE; a start
  // seen elsewhere (including alongside ack in DONE) is dropped, never queued.
  state_t state;
  state_t state_next;
  ctrl_t  ctrl_next;
  ctrl_t  ctrl_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = ADD_AB;
      ADD_AB:  state_next = (OPS >= 3) ? ADD_C : OUT;
      ADD_C:   state_next = (OPS == 4) ? ADD_D : OUT;
      ADD_D:   state_next = OUT;
      OUT:     state_next = DONE;
      DONE:    if (ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decoding the next state into a register keeps every strobe glitch-free
  // while still lining up exactly with the current state.
  assign ctrl_next = decode_state(state_next);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= CTRL_IDLE;
    end else begin
      ctrl_q <= ctrl_next;
    end
  end

  assign aload         = ctrl_q.load;
  assign bload         = ctrl_q.load;
  assign cload         = ctrl_q.load;
  assign dload         = ctrl_q.load;
  assign asel          = ctrl_q.asel;
  assign bsel          = ctrl_q.bsel;
  assign output_enable = ctrl_q.output_enable;
  assign busy          = ctrl_q.busy;
  assign done          = ctrl_q.done;
  assign state_dbg     = state;

`ifdef ADDER_CTRL_TXN_COUNT_EN
  logic txn_done;
  assign txn_done = (state == DONE) && ack;

  adder_txn_counter #(
    .CNT_W(CNT_W)
  ) u_txn_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (txn_done),
    .count(txn_count)
  );
`else
  logic cnt_w_unused;
  assign cnt_w_unused = (CNT_W > 0);
`endif

endmodule

// File: doc/adder_controller.md
# adder_controller

Control FSM sitting directly upstream of the four-operand adder datapath. Accepts a start request, then sequences the datapath through load, A+B, +C, +D and output-register phases by driving its `aload/bload/cload/dload`, `asel`, `bsel` and `output_enable` inputs. Reports completion with a done/ack handshake so a host or testbench knows when `o_sum` is valid.

## Interface
- `NUM_OPS`, default 4: operands summed. Legal values are 2, 3 and 4. Any other value behaves as 4.
- `CNT_W`, default 8: width of `txn_count`. Only used when the counter is compiled in.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. Asserting `rst`=0 resets immediately; release is synchronous to `clk`.
- `start`  in  1  request a new sum. Sampled only in IDLE.
- `ack`  in  1  host acknowledges the result. Sampled only in DONE.
- `aload`, `bload`, `cload`, `dload`  out  1 each  operand-load strobes to the datapath. Always driven identically.
- `asel`  out  1  datapath A-select.
- `bsel`  out  2  datapath operation select.
- `output_enable`  out  1  copies the datapath sum into `o_sum`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  high while in DONE; `o_sum` is valid.
- `txn_count`  out  CNT_W  completed transactions. Present only with the macro described under Configuration.

## Operation
- Datapath contract: assert at most one action per cycle. Every other strobe must be low.
- The no-op encoding is `asel`=0, `bsel`=2'b11, with loads and `output_enable` at 0.
- States and their outputs:
  - IDLE: no-op.
  - LOAD: all four loads = 1.
  - ADD_AB: `asel`=1, `bsel`=00.
  - ADD_C: `asel`=0, `bsel`=01.
  - ADD_D: `asel`=0, `bsel`=10.
  - OUT: `output_enable`=1.
  - DONE: no-op, `done`=1.
- Transitions:
  - IDLE→LOAD when `start`=1.
  - LOAD→ADD_AB.
  - ADD_AB→ADD_C when NUM_OPS≥3, otherwise →OUT.
  - ADD_C→ADD_D when NUM_OPS=4, otherwise →OUT.
  - ADD_D→OUT.
  - OUT→DONE.
  - DONE→IDLE when `ack`=1.
- Outputs are Moore, decoded from the state register only. They must be glitch-free relative to `clk`, so register them or decode them directly from a one-hot state.
- `start` in any state other than IDLE is ignored and is not queued.
- `ack` outside DONE is ignored.
- `start` and `ack` asserted together in DONE: the ack completes and the FSM goes to IDLE. That `start` is dropped and must be reasserted in IDLE.
- `start` held high continuously: a new transaction begins in the first IDLE cycle after each ack. There is exactly one IDLE cycle between transactions.
- Reset mid-operation: the FSM returns to IDLE at once, all outputs go to no-op, and any partial transaction is abandoned. `txn_count` clears.
- Reset values:
  - State is IDLE.
  - `aload`..`dload`, `asel`, `output_enable`, `busy` and `done` are 0.
  - `bsel` is 2'b11.
  - `txn_count` is 0.

## Timing
- `start` sampled high at edge N puts LOAD outputs in cycle N+1.
- Cycles from the `start` edge to `done`=1 (DONE state entered): NUM_OPS=4 takes 6, NUM_OPS=3 takes 5, NUM_OPS=2 takes 4.
- The datapath updates `o_sum` on the edge that leaves OUT, so `o_sum` is stable whenever `done`=1.
- `ack` sampled high at edge M drops `done` and `busy` in cycle M+1.
- Minimum start-to-start period is NUM_OPS+3 cycles, assuming ack is given in the first DONE cycle.
- `txn_count` increments on the DONE→IDLE edge and wraps modulo 2^CNT_W.

## Configuration
- Macro `ADDER_CTRL_TXN_COUNT_EN`.
- Defined: the `txn_count` port and counter exist, behaving as above.
- Undefined: the port and counter logic are absent. All other behaviour is identical.

## Structure
- Shared package `adder_ctrl_pkg` holds:
  - State encoding constants: IDLE, LOAD, ADD_AB, ADD_C, ADD_D, OUT, DONE.
  - `bsel` codes: BSEL_AB=2'b00, BSEL_C=2'b01, BSEL_D=2'b10, BSEL_NOP=2'b11.
- One sub-module, `adder_txn_counter`: a CNT_W-bit wrapping counter with increment enable and the async active-low reset. It is instantiated only under `ADDER_CTRL_TXN_COUNT_EN`.

## Test plan
The bench instantiates `adder_controller` driving the adder datapath.
- Basic sum: reset, release, then NUM_OPS=4 with A=3, B=4, C=5, D=6 and a 1-cycle `start` → `done` rises 6 cycles after the `start` edge with `o_sum`=18. Control sequence is LOAD, AB, C, D, OUT with exactly one action per cycle.
- Reduced operand count:
  - NUM_OPS=2 with A=15, B=15 → `o_sum`=30 and `done` after 4 cycles. `bsel`=01 and `bsel`=10 never appear.
  - NUM_OPS=3 with A=1, B=2, C=3 → `o_sum`=6 after 5 cycles.
- Handshake edges:
  - `start` pulsed during ADD_C → ignored. Only one transaction occurs.
  - `ack` held off for 10 cycles → `done` and `o_sum` stay stable for all 10.
  - `start` and `ack` together in DONE → IDLE, no new transaction.
- Reset mid-operation: `rst`=0 during ADD_AB → all outputs at reset values in the same cycle. After release, IDLE persists until `start`.
- Counter, with macro defined and CNT_W=2: 5 complete transactions → `txn_count` reads 1,2,3,0,1. With the macro undefined the design compiles without the port.
